// File: rtl/axi_burst_master.sv
// AXI3 burst master: bridges one CPU-side request port onto AXI, one INCR transaction in flight.
// Reads stream back on rbeat_*. Writes pass straight through from wbeat_* to the W channel.
module axi_burst_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned MAX_LEN = 16,
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_len,
    input  logic [2:0]        req_size,
    input  logic [ID_W-1:0]   req_id,
    input  logic              wbeat_valid,
    output logic              wbeat_ready,
    input  logic [DATA_W-1:0] wbeat_data,
    input  logic [STRB_W-1:0] wbeat_strb,
    output logic              rbeat_valid,
    output logic [DATA_W-1:0] rbeat_data,
    output logic              rbeat_last,
    output logic              done,
    output logic              err,
    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [3:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [1:0]        m_arlock,
    output logic [3:0]        m_arcache,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [ID_W-1:0]   m_awid,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [3:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic [1:0]        m_awlock,
    output logic [3:0]        m_awcache,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [ID_W-1:0]   m_wid,
    output logic [DATA_W-1:0] m_wdata,
    output logic [STRB_W-1:0] m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [ID_W-1:0]   m_bid,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_ERR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [ID_W-1:0]   id_q;
    logic [7:0]        cnt_q;
    logic              err_q;
    logic              r_beat_err;
    logic              unused_ids;

    // A beat is bad on a non-OKAY response or when RLAST disagrees with the expected final beat.
    assign r_beat_err = (m_rresp != 2'b00) || (m_rlast != (cnt_q == len_q));
    assign unused_ids = ^{m_rid, m_bid};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            req_ready   <= 1'b0;
            m_arvalid   <= 1'b0;
            m_awvalid   <= 1'b0;
            m_rready    <= 1'b0;
            m_bready    <= 1'b0;
            rbeat_valid <= 1'b0;
            rbeat_data  <= '0;
            rbeat_last  <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            rbeat_valid <= 1'b0;
            rbeat_last  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        len_q     <= req_len;
                        size_q    <= req_size;
                        id_q      <= req_id;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        req_ready <= 1'b0;
                        if (req_len >= 8'(MAX_LEN)) begin
                            state <= S_ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (req_we) begin
                            state     <= S_AW;
                            m_awvalid <= 1'b1;
                        end else begin
                            state     <= S_AR;
                            m_arvalid <= 1'b1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_AR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= S_R;
                    end
                end
                S_R: begin
                    if (m_rvalid) begin
                        rbeat_valid <= 1'b1;
                        rbeat_data  <= m_rdata;
                        rbeat_last  <= m_rlast;
                        cnt_q       <= cnt_q + 8'd1;
                        if (m_rlast) begin
                            m_rready <= 1'b0;
                            done     <= 1'b1;
                            err      <= err_q | r_beat_err;
                            state    <= S_IDLE;
                        end else begin
                            err_q <= err_q | r_beat_err;
                        end
                    end
                end
                S_AW: begin
                    if (m_awready) begin
                        m_awvalid <= 1'b0;
                        state     <= S_W;
                    end
                end
                S_W: begin
                    if (m_wvalid && m_wready) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == len_q) begin
                            m_bready <= 1'b1;
                            state    <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (m_bvalid) begin
                        m_bready <= 1'b0;
                        done     <= 1'b1;
                        err      <= err_q | (m_bresp != 2'b00);
                        state    <= S_IDLE;
                    end
                end
                S_ERR: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // W channel is a direct pass-through, gated so no beat can leave before AW completes.
    assign m_wvalid    = (state == S_W) && wbeat_valid;
    assign wbeat_ready = (state == S_W) && m_wready;
    assign m_wlast     = (state == S_W) && (cnt_q == len_q);
    assign m_wdata     = wbeat_data;
    assign m_wstrb     = wbeat_strb;
    assign m_wid       = id_q;

    assign m_arid    = id_q;
    assign m_araddr  = addr_q;
    assign m_arlen   = 4'(len_q);
    assign m_arsize  = size_q;
    assign m_arburst = 2'b01;
    assign m_arlock  = 2'b00;
    assign m_arcache = 4'b0000;
    assign m_arprot  = 3'b000;

    assign m_awid    = id_q;
    assign m_awaddr  = addr_q;
    assign m_awlen   = 4'(len_q);
    assign m_awsize  = size_q;
    assign m_awburst = 2'b01;
    assign m_awlock  = 2'b00;
    assign m_awcache = 4'b0000;
    assign m_awprot  = 3'b000;

endmodule
